// File: rtl/fpxx_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpxx_add_arbiter
//  Purpose  : Shares one fully pipelined fp32 adder (fixed latency, no stall)
//             among NUM_REQ requesters. A round-robin arbiter grants at most
//             one request per cycle and registers its operands into the adder.
//             A {valid,id} tag pipe tracks each op, so every sum returns
//             labelled with the requester that issued it.
//  Ports    : osc_clk, reset      clock / synchronous active-high reset
//             req_valid/req_ready per-requester handshake (ready is one-hot/0)
//             req_op_a/req_op_b   packed operands, requester i at [32*i+:32]
//             hold                suppresses new grants for this cycle
//             add_op_a/add_op_b   registered operands to the adder
//             add_result          adder sum, ADD_LATENCY after operands
//             rsp_valid/id/data   registered result strobe, owner and sum
//             inflight, busy      ops issued but not yet returned
//  Revision : 1.0  initial release
// ============================================================================
module fpxx_add_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int ADD_LATENCY = 3,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int INF_W       = $clog2(ADD_LATENCY + 3)
) (
  input  logic                   osc_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op_a,
  input  logic [32*NUM_REQ-1:0]  req_op_b,
  input  logic                   hold,
  output logic [31:0]            add_op_a,
  output logic [31:0]            add_op_b,
  input  logic [31:0]            add_result,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic [INF_W-1:0]       inflight,
  output logic                   busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             issue;

  logic [ADD_LATENCY:0] tag_valid;
  logic [ID_W-1:0]      tag_id [ADD_LATENCY+1];

  // Round-robin search. The loop runs from the farthest candidate back to
  // rr_ptr so the last match written is the first one in search order.
  // Gating with reset keeps req_ready low while reset is asserted.
  always_comb begin
    issue    = 1'b0;
    grant_id = '0;
    if (!reset && !hold) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          issue    = 1'b1;
          grant_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Pointer and operand registers; operands keep their last value when idle.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      add_op_a <= '0;
      add_op_b <= '0;
    end else if (issue) begin
      rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      add_op_a <= req_op_a[32*grant_id +: 32];
      add_op_b <= req_op_b[32*grant_id +: 32];
    end
  end

  // Tag pipe: stage 0 captures the issue, the last stage lines up with the
  // sum coming out of the adder. Only the valid bits need clearing.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      tag_valid <= '0;
    end else begin
      tag_valid <= {tag_valid[ADD_LATENCY-1:0], issue};
    end
  end

  always_ff @(posedge osc_clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k <= ADD_LATENCY; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

  // Result register: the adder output is trusted only under a valid tag.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_valid[ADD_LATENCY];
      if (tag_valid[ADD_LATENCY]) begin
        rsp_id   <= tag_id[ADD_LATENCY];
        rsp_data <= add_result;
      end
    end
  end

  // Occupancy: an op leaves the count on the edge where its rsp_valid is seen.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue, rsp_valid})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_fpxx_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpxx_add_arbiter
//  Purpose  : Self-checking bench for fpxx_add_arbiter (NUM_REQ=4,
//             ADD_LATENCY=3). A behavioural fp32 adder stub sits on the adder
//             port; a round-robin model and an expected-result queue are
//             stepped once per clock; table rows carry explicit grant values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpxx_add_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ADD_LATENCY = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_op_a;
  logic [127:0] req_op_b;
  logic         hold;
  logic [31:0]  add_op_a;
  logic [31:0]  add_op_b;
  logic [31:0]  add_result;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [2:0]   inflight;
  logic         busy;

  always #5 clk = ~clk;

  fpxx_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LATENCY(ADD_LATENCY)) dut (
    .osc_clk    (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .hold       (hold),
    .add_op_a   (add_op_a),
    .add_op_b   (add_op_b),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .inflight   (inflight),
    .busy       (busy)
  );

  // Positive normal fp32 addition, truncating; exact for the operands used.
  function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [7:0]  d;
    logic [24:0] ma, mb, s;
    a = a_in;
    b = b_in;
    if (a[30:23] < b[30:23]) begin
      a = b_in;
      b = a_in;
    end
    d  = a[30:23] - b[30:23];
    ma = {2'b01, a[22:0]};
    mb = (d > 8'd24) ? 25'd0 : ({2'b01, b[22:0]} >> d);
    s  = ma + mb;
    if (s[24]) return {1'b0, a[30:23] + 8'd1, s[23:1]};
    return {1'b0, a[30:23], s[22:0]};
  endfunction

  // Adder stub: ADD_LATENCY register stages after the DUT operand registers.
  logic [31:0] apipe [ADD_LATENCY];
  always_ff @(posedge clk) begin
    apipe[0] <= fadd(add_op_a, add_op_b);
    for (int k = 1; k < ADD_LATENCY; k++) apipe[k] <= apipe[k-1];
  end
  assign add_result = apipe[ADD_LATENCY-1];

  logic [31:0] opa [4];
  logic [31:0] opb [4];
  always_comb begin
    req_op_a = '0;
    req_op_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_op_a[32*i +: 32] = opa[i];
      req_op_b[32*i +: 32] = opb[i];
    end
  end

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic       hold;
    logic [3:0] ready;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl [33];
  int          n_vec = 0;
  int          n_err = 0;
  int          ptr;
  int          ecount;
  int          max_inf;
  int          hold_rsp;
  int          id_log[$];
  logic [31:0] rsp_by_id [4];
  logic [3:0]  last_ready;
  logic        busy_seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, got, exp, ecount);
    end
  endtask

  // One clock: inputs are already driven; check at the falling edge, then
  // advance the reference model across the rising edge.
  task automatic tick();
    logic [3:0] er;
    int         gid;
    int         j;
    exp_t       e;
    @(negedge clk);
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (int'(inflight) > max_inf) max_inf = int'(inflight);
    busy_seen = busy;
    er  = '0;
    gid = -1;
    if (!reset && !hold) begin
      for (int k = 0; k < 4; k++) begin
        j = (ptr + k) % 4;
        if (gid < 0 && req_valid[j]) begin
          gid   = j;
          er[j] = 1'b1;
        end
      end
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    last_ready = req_ready;
    if (q.size() > 0 && q[0].due == ecount) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_data", rsp_data, e.data);
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    if (rsp_valid) begin
      rsp_by_id[rsp_id] = rsp_data;
      id_log.push_back(int'(rsp_id));
      if (hold) hold_rsp++;
    end
    if (gid >= 0) begin
      e.id   = 2'(gid);
      e.data = fadd(opa[gid], opb[gid]);
      e.due  = ecount + 5;
      q.push_back(e);
      ptr = (gid + 1) % 4;
    end
    @(posedge clk);
    ecount++;
    if (reset) begin
      q.delete();
      ptr = 0;
    end
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_valid = tbl[i].valid;
      hold      = tbl[i].hold;
      tick();
      chk($sformatf("row%0d_ready", i), 32'(last_ready), 32'(tbl[i].ready));
    end
    req_valid = '0;
    hold      = 1'b0;
  endtask

  task automatic setrow(input int i, input logic [3:0] v, input logic h, input logic [3:0] r);
    tbl[i].valid = v;
    tbl[i].hold  = h;
    tbl[i].ready = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    ptr       = 0;
    ecount    = 0;
    max_inf   = 0;
    hold_rsp  = 0;
    busy_seen = 1'b0;
    opa[0] = 32'h3F800000; opb[0] = 32'h3F800000;  // 1.0 + 1.0
    opa[1] = 32'h40000000; opb[1] = 32'h40000000;  // 2.0 + 2.0
    opa[2] = 32'h3F000000; opb[2] = 32'h3F800000;  // 0.5 + 1.0
    opa[3] = 32'h40400000; opb[3] = 32'h3FC00000;  // 3.0 + 1.5
    for (int i = 0; i < 4; i++) rsp_by_id[i] = '0;

    // Four-way contention, requesters drop valid once served, then drain.
    setrow(0, 4'b1111, 1'b0, 4'b0001);
    setrow(1, 4'b1110, 1'b0, 4'b0010);
    setrow(2, 4'b1100, 1'b0, 4'b0100);
    setrow(3, 4'b1000, 1'b0, 4'b1000);
    for (int i = 4; i <= 9; i++) setrow(i, 4'b0000, 1'b0, 4'b0000);
    // Single op from requester 0.
    setrow(10, 4'b0001, 1'b0, 4'b0001);
    for (int i = 11; i <= 16; i++) setrow(i, 4'b0000, 1'b0, 4'b0000);
    // Requesters 0 and 2 held valid: strict alternation.
    for (int i = 17; i <= 22; i++)
      setrow(i, 4'b0101, 1'b0, (i % 2 == 1) ? 4'b0100 : 4'b0001);
    // Hold for three cycles with requester 1 waiting, then it wins at once.
    for (int i = 23; i <= 25; i++) setrow(i, 4'b0010, 1'b1, 4'b0000);
    setrow(26, 4'b0010, 1'b0, 4'b0010);
    for (int i = 27; i <= 32; i++) setrow(i, 4'b0000, 1'b0, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_add_op_a", add_op_a, 32'd0);
    chk("reset_add_op_b", add_op_b, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_inflight", 32'(inflight), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_rows(0, 9);
    chk("fourway_rsp_count", 32'(id_log.size()), 32'd4);
    if (id_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("fourway_order%0d", i), 32'(id_log[i]), 32'(i));
    end
    chk("fourway_sum_req3", rsp_by_id[3], 32'h40900000);
    chk("fourway_sum_req1", rsp_by_id[1], 32'h40800000);
    chk("fourway_sum_req2", rsp_by_id[2], 32'h3FC00000);

    id_log.delete();
    rsp_by_id[0] = '0;
    run_rows(10, 16);
    chk("single_rsp_count", 32'(id_log.size()), 32'd1);
    chk("single_sum", rsp_by_id[0], 32'h40000000);

    hold_rsp = 0;
    run_rows(17, 32);
    chk("hold_inflight_returns", 32'(hold_rsp > 0), 32'd1);

    // Streaming: requester 0 issues twenty back-to-back ops.
    max_inf   = 0;
    req_valid = 4'b0001;
    repeat (20) tick();
    req_valid = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_seen && n < 20);
    chk("stream_max_inflight", 32'(max_inf), 32'd5);
    chk("stream_busy_fall_edges", 32'(n - 1), 32'd5);

    // Reset two cycles after three issues discards everything in flight.
    req_valid = 4'b0110;
    repeat (3) tick();
    req_valid = 4'b0000;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("post_reset_inflight", 32'(inflight), 32'd0);
    req_valid = 4'b1111;
    tick();
    chk("post_reset_grant", 32'(last_ready), 32'b0001);
    req_valid = 4'b0000;
    repeat (7) tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
